// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory-mapped slave with an internal word RAM: FIXED/INCR/WRAP bursts,
// byte strobes, ID echo, SLVERR for illegal bursts and DECERR beyond the array.
module axi4_burst_mem_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024,
    parameter int ID_WIDTH     = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [1:0]              dbg_w_state_o,
    output logic [1:0]              dbg_r_state_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LNB = $clog2(NB);
    localparam int IW  = $clog2(MEMORY_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    // Handshake rule on every channel: a transfer happens on the rising edge where VALID and READY are both high.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] span;
        logic        err;
        span = ({24'd0, len} + 32'd1) << size;
        err  = 1'b0;
        if ({29'd0, size} > 32'(LNB)) err = 1'b1;
        if (burst == 2'b11) err = 1'b1;
        if (burst == 2'b10 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
            ((32'(addr) & ((32'd1 << size) - 32'd1)) != 32'd0))) err = 1'b1;
        if (burst == 2'b01 && ((32'(addr) & 32'hFFF) + span) > 32'h1000) err = 1'b1;
        return err;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                                        input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a, step, wlen, nxt;
        a    = 32'(addr);
        step = 32'd1 << size;
        wlen = ({24'd0, len} + 32'd1) << size;
        case (burst)
            2'b01:   nxt = a + step;
            2'b10:   nxt = (a & ~(wlen - 32'd1)) + ((a + step) & (wlen - 32'd1));
            default: nxt = a;
        endcase
        return ADDR_WIDTH'(nxt);
    endfunction

    function automatic logic beat_decerr(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) >> LNB) >= 32'(MEMORY_DEPTH);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IW'(addr >> LNB);
    endfunction

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q, bresp_q;
    logic                  werr_q;
    logic                  aw_hs, w_hs, w_last_beat, w_decerr, mem_we;

    assign aw_hs       = AWVALID && (w_state_q == W_IDLE);
    assign w_hs        = WVALID && (w_state_q == W_DATA);
    assign w_last_beat = (wcnt_q == wlen_q);
    assign w_decerr    = beat_decerr(waddr_q);
    assign mem_we      = w_hs && !werr_q && !w_decerr;

    always_comb begin
        w_state_d = w_state_q;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) w_state_d = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awid_q   <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (aw_hs) begin
            awid_q   <= AWID;
            waddr_q  <= AWADDR;
            wlen_q   <= AWLEN;
            wcnt_q   <= '0;
            wsize_q  <= AWSIZE;
            wburst_q <= AWBURST;
            werr_q   <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
            bresp_q  <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST) ? RESP_SLVERR : RESP_OKAY;
        end else if (w_hs) begin
            wcnt_q  <= wcnt_q + 8'd1;
            waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
            // SLVERR outranks DECERR, so DECERR only lands on a still-clean response.
            if (WLAST != w_last_beat) bresp_q <= RESP_SLVERR;
            else if (w_decerr && bresp_q == RESP_OKAY) bresp_q <= RESP_DECERR;
        end
    end

    assign BID   = awid_q;
    assign BRESP = bresp_q;

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (WSTRB[b]) mem_q[word_idx(waddr_q)][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]            rlen_q, rcnt_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q, rresp_q;
    logic                  rerr_q, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ar_hs, r_fetch, r_hs;

    assign ar_hs   = ARVALID && (r_state_q == R_IDLE);
    assign r_fetch = (r_state_q == R_FETCH);
    assign r_hs    = RREADY && (r_state_q == R_DATA);

    always_comb begin
        r_state_d = r_state_q;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) r_state_d = R_FETCH;
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) r_state_d = rlast_q ? R_IDLE : R_FETCH;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    // Array read happens in R_FETCH; a same-edge write is not yet visible, so reads see pre-write data.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else if (ar_hs) begin
            rid_q    <= ARID;
            raddr_q  <= ARADDR;
            rlen_q   <= ARLEN;
            rcnt_q   <= '0;
            rsize_q  <= ARSIZE;
            rburst_q <= ARBURST;
            rerr_q   <= burst_err(ARADDR, ARLEN, ARSIZE, ARBURST);
        end else if (r_fetch) begin
            rlast_q <= (rcnt_q == rlen_q);
            if (rerr_q) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else if (beat_decerr(raddr_q)) begin
                rdata_q <= '0;
                rresp_q <= RESP_DECERR;
            end else begin
                rdata_q <= mem_q[word_idx(raddr_q)];
                rresp_q <= RESP_OKAY;
            end
        end else if (r_hs) begin
            rlast_q <= 1'b0;
            if (!rlast_q) begin
                rcnt_q  <= rcnt_q + 8'd1;
                raddr_q <= next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
            end
        end
    end

    assign RID   = rid_q;
    assign RDATA = rdata_q;
    assign RRESP = rresp_q;
    assign RLAST = rlast_q;

    assign dbg_w_state_o = w_state_q;
    assign dbg_r_state_o = r_state_q;
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed and randomized bench for axi4_burst_mem_slave, checked against a
// byte-addressed memory model with closed-form burst address arithmetic.
module tb_axi4_burst_mem_slave;
    localparam int DW = 32, AW = 16, DEPTH = 1024, IDW = 4, NB = 4;

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic [IDW-1:0]  AWID, ARID, BID, RID;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic [7:0]      AWLEN, ARLEN;
    logic [2:0]      AWSIZE, ARSIZE;
    logic [1:0]      AWBURST, ARBURST, BRESP, RRESP;
    logic            AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic            ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DW-1:0]   WDATA, RDATA;
    logic [NB-1:0]   WSTRB;
    logic [1:0]      dbg_w_state, dbg_r_state;

    always #5 ACLK = ~ACLK;

    axi4_burst_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mdl   [0:4095];
    logic [31:0] wdat  [0:255];
    logic [3:0]  wstb  [0:255];
    logic [31:0] r_obs [0:255];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input int addr, input int len, input int size, input int burst);
        if (size > 2 || burst == 3) return 1'b1;
        if (burst == 2) return !(len == 1 || len == 3 || len == 7 || len == 15) || (addr % (1 << size)) != 0;
        if (burst == 1) return (addr % 4096) + ((len + 1) << size) > 4096;
        return 1'b0;
    endfunction

    function automatic int m_addr(input int start, input int len, input int size, input int burst, input int i);
        int w;
        int base;
        if (burst == 0) return start;
        if (burst == 1) return start + i * (1 << size);
        w    = (len + 1) << size;
        base = start - (start % w);
        return base + ((start - base) + i * (1 << size)) % w;
    endfunction

    task automatic m_beat(input int a, input bit err, output logic [31:0] d, output logic [1:0] r);
        int w;
        w = a - (a % 4);
        if (err) begin
            d = 32'd0; r = 2'b10;
        end else if ((a / 4) >= DEPTH) begin
            d = 32'd0; r = 2'b11;
        end else begin
            d = {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]}; r = 2'b00;
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_awready"}, 64'(AWREADY), 64'd1);
        chk({p, "_arready"}, 64'(ARREADY), 64'd1);
        chk({p, "_wready"},  64'(WREADY),  64'd0);
        chk({p, "_bvalid"},  64'(BVALID),  64'd0);
        chk({p, "_rvalid"},  64'(RVALID),  64'd0);
        chk({p, "_rlast"},   64'(RLAST),   64'd0);
        chk({p, "_bresp"},   64'(BRESP),   64'd0);
        chk({p, "_rresp"},   64'(RRESP),   64'd0);
        chk({p, "_bid"},     64'(BID),     64'd0);
        chk({p, "_rid"},     64'(RID),     64'd0);
        chk({p, "_rdata"},   64'(RDATA),   64'd0);
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cnt;
        cnt = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (!AWREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
        chk("awready_wait", 64'(AWREADY), 64'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("awready_low", 64'(AWREADY), 64'd0);
        chk("wready_high", 64'(WREADY), 64'd1);
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input bit last);
        int cnt;
        cnt = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        while (!WREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
        chk("wready_wait", 64'(WREADY), 64'd1);
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cnt;
        cnt = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        while (!ARREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
        chk("arready_wait", 64'(ARREADY), 64'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("arready_low", 64'(ARREADY), 64'd0);
        chk("rvalid_fetch", 64'(RVALID), 64'd0);
    endtask

    task automatic r_recv(input logic [31:0] ed, input logic [1:0] er, input bit el, input logic [3:0] eid,
                          input int stall, output logic [31:0] obs);
        int          cnt;
        logic [31:0] d0;
        cnt = 0;
        while (!RVALID && cnt < 100) begin @(negedge ACLK); cnt++; end
        chk("r_latency", 64'(cnt), 64'd1);
        d0 = RDATA;
        for (int k = 0; k < stall; k++) begin
            @(negedge ACLK);
            chk("rvalid_hold", 64'(RVALID), 64'd1);
            chk("rdata_hold", 64'(RDATA), 64'(d0));
        end
        chk("rdata", 64'(RDATA), 64'(ed));
        chk("rresp", 64'(RRESP), 64'(er));
        chk("rlast", 64'(RLAST), 64'(el));
        chk("rid", 64'(RID), 64'(eid));
        obs = RDATA;
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input int addr, input int len, input int size,
                            input int burst, input bit bad_last);
        bit         err;
        bit         dec;
        int         a;
        logic [1:0] eresp;
        err = m_err(addr, len, size, burst);
        dec = 1'b0;
        aw_send(id, 16'(addr), 8'(len), 3'(size), 2'(burst));
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge ACLK);
            w_send(wdat[i], wstb[i], (i == len) ^ (bad_last && i == len));
            a = m_addr(addr, len, size, burst, i);
            if ((a / 4) >= DEPTH) dec = 1'b1;
            else if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mdl[a - (a % 4) + b] = wdat[i][b*8 +: 8];
            end
        end
        eresp = (err || bad_last) ? 2'b10 : (dec ? 2'b11 : 2'b00);
        chk("bvalid", 64'(BVALID), 64'd1);
        chk("bid", 64'(BID), 64'(id));
        chk("bresp", 64'(BRESP), 64'(eresp));
        repeat ($urandom_range(0, 2)) begin
            @(negedge ACLK);
            chk("bvalid_hold", 64'(BVALID), 64'd1);
            chk("bresp_hold", 64'(BRESP), 64'(eresp));
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("b_done", 64'(BVALID), 64'd0);
        chk("awready_idle", 64'(AWREADY), 64'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input int addr, input int len, input int size,
                           input int burst, input int stall);
        bit          err;
        logic [31:0] d;
        logic [1:0]  r;
        err = m_err(addr, len, size, burst);
        ar_send(id, 16'(addr), 8'(len), 3'(size), 2'(burst));
        for (int i = 0; i <= len; i++) begin
            m_beat(m_addr(addr, len, size, burst, i), err, d, r);
            r_recv(d, r, i == len, id, stall, r_obs[i]);
        end
        chk("rvalid_idle", 64'(RVALID), 64'd0);
        chk("rlast_idle", 64'(RLAST), 64'd0);
        chk("arready_idle", 64'(ARREADY), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ff8_w0, ff8_w1, d;
        logic [1:0]  r;
        int          wl [5];
        int          burst, size, len, addr, step;
        wl = '{1, 2, 3, 7, 15};
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        chk_reset_vals("reset");
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Preload bytes 0x000-0x3FF and the two words just below the 4 KB boundary.
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            do_write(4'(blk), blk * 64, 15, 2, 1, 1'b0);
        end
        ff8_w0 = $urandom; ff8_w1 = $urandom;
        wdat[0] = ff8_w0; wdat[1] = ff8_w1; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(4'd1, 'h0FF8, 1, 2, 1, 1'b0);

        // INCR write and read-back with IDs.
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h11111111 * (i + 1); wstb[i] = 4'hF; end
        do_write(4'd5, 'h0010, 3, 2, 1, 1'b0);
        do_read(4'd9, 'h0010, 3, 2, 1, 0);
        for (int i = 0; i < 4; i++) chk("t1_incr_beat", 64'(r_obs[i]), 64'(32'h11111111 * (i + 1)));

        // WRAP read crossing the wrap boundary.
        do_read(4'd3, 'h0018, 3, 2, 2, 0);
        chk("t2_wrap0", 64'(r_obs[0]), 64'h33333333);
        chk("t2_wrap1", 64'(r_obs[1]), 64'h44444444);
        chk("t2_wrap2", 64'(r_obs[2]), 64'h11111111);
        chk("t2_wrap3", 64'(r_obs[3]), 64'h22222222);

        // Byte strobes, including an all-zero strobe beat.
        wdat[0] = 32'h12345678; wstb[0] = 4'hF;
        do_write(4'd2, 'h0100, 0, 2, 1, 1'b0);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
        do_write(4'd2, 'h0100, 0, 2, 1, 1'b0);
        do_read(4'd2, 'h0100, 0, 2, 1, 0);
        chk("t3_strobe", 64'(r_obs[0]), 64'h12BB56DD);
        wdat[0] = $urandom; wstb[0] = 4'h0;
        do_write(4'd2, 'h0100, 0, 2, 1, 1'b0);
        do_read(4'd2, 'h0100, 0, 2, 1, 0);
        chk("t3_zero_strobe", 64'(r_obs[0]), 64'h12BB56DD);

        // Error bursts: 4 KB crossing, out-of-range, bad WRAP length, reserved type, oversize, WLAST mismatch.
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        do_write(4'd4, 'h0FF8, 3, 2, 1, 1'b0);
        do_read(4'd4, 'h0FF8, 1, 2, 1, 0);
        chk("t4_unchanged0", 64'(r_obs[0]), 64'(ff8_w0));
        chk("t4_unchanged1", 64'(r_obs[1]), 64'(ff8_w1));
        do_read(4'd6, 'h1000, 0, 2, 1, 0);
        do_write(4'd8, 'h1000, 0, 2, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        do_write(4'd7, 'h0040, 2, 2, 2, 1'b0);
        do_read(4'd7, 'h0040, 2, 2, 2, 0);
        do_write(4'd7, 'h0040, 0, 2, 3, 1'b0);
        do_write(4'd7, 'h0040, 0, 3, 1, 1'b0);
        do_read(4'd7, 'h0040, 3, 2, 1, 0);
        for (int i = 0; i < 2; i++) begin
            m_beat('h80 + 4 * i, 1'b0, d, r);
            wdat[i] = d; wstb[i] = 4'hF;
        end
        do_write(4'd13, 'h0080, 1, 2, 1, 1'b1);

        // FIXED write keeps the last beat; long RREADY stall holds the read beat.
        wdat[0] = 32'hA0A0A0A0; wdat[1] = 32'hB0B0B0B0; wdat[2] = 32'hC0C0C0C0;
        for (int i = 0; i < 3; i++) wstb[i] = 4'hF;
        do_write(4'd10, 'h0020, 2, 2, 0, 1'b0);
        do_read(4'd10, 'h0020, 2, 2, 0, 5);
        for (int i = 0; i < 3; i++) chk("t5_fixed", 64'(r_obs[i]), 64'hC0C0C0C0);

        // Randomized bursts inside the preloaded region.
        for (int t = 0; t < 40; t++) begin
            burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            len   = (burst == 2) ? wl[$urandom_range(0, 4)] : int'($urandom_range(0, 15));
            step  = 1 << size;
            addr  = $urandom_range(0, 'h3FF - len * step);
            if (burst == 2) addr = $urandom_range(0, 'h3FF) & ~(step - 1);
            for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
            do_write(4'($urandom_range(0, 15)), addr, len, size, burst, 1'b0);
            do_read(4'($urandom_range(0, 15)), addr, len, size, burst, $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of an 8-beat write and an 8-beat read.
        aw_send(4'd11, 16'h0200, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) begin
            wdat[i] = $urandom;
            w_send(wdat[i], 4'hF, 1'b0);
            for (int b = 0; b < 4; b++) mdl['h200 + 4 * i + b] = wdat[i][b*8 +: 8];
        end
        ar_send(4'd12, 16'h0100, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) begin
            m_beat('h100 + 4 * i, 1'b0, d, r);
            r_recv(d, r, 1'b0, 4'd12, 0, r_obs[i]);
        end
        #2 ARESETn = 1'b0;
        #1 chk_reset_vals("rst_mid");
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        wdat[0] = $urandom; wstb[0] = 4'hF;
        do_write(4'd14, 'h0300, 0, 2, 1, 1'b0);
        do_read(4'd15, 'h0300, 0, 2, 1, 0);
        do_read(4'd1, 'h0200, 2, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview:
Next-generation AXI4 memory-mapped slave with integrated word memory, for use as a verification target and scratch RAM. Over the previous slave it adds the FIXED, INCR and WRAP burst types, WSTRB byte-lane writes, transaction IDs echoed on B/R, DECERR reporting, and parametrised ID and data width. Write and read channels run independently on one clock and share a one-write, one-read internal array.

Parameters:
DATA_WIDTH, 32, data bus width in bits; legal values 32 or 64; NB = DATA_WIDTH/8 bytes per beat.
ADDR_WIDTH, 16, byte address width.
MEMORY_DEPTH, 1024, number of DATA_WIDTH-bit words.
ID_WIDTH, 4, width of AWID/BID/ARID/RID.

Ports:
ACLK  in  1  clock, all logic on the rising edge.
ARESETn  in  1  asynchronous active-low reset.
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address; AWBURST 00=FIXED, 01=INCR, 10=WRAP.
AWVALID in 1; AWREADY out 1  write address handshake.
WDATA/WSTRB/WLAST/WVALID  in  DATA_WIDTH/NB/1/1  write data; WREADY out 1.
BID/BRESP/BVALID  out  ID_WIDTH/2/1  write response; BREADY in 1.
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  as AW*  read address; ARREADY out 1.
RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; RREADY in 1.

Behaviour:
- Interface: one clock ACLK; reset ARESETn is asynchronous and active-low.
- Reset values: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP = 00; BID, RID, RDATA = 0.
- Reset: FSMs go to IDLE immediately, including mid-burst. Memory contents are not cleared.
- Word index = byte address >> log2(NB).
- Burst address step:
  - FIXED: address is constant.
  - INCR: address += 1<<SIZE.
  - WRAP: W = (LEN+1)<<SIZE; base = start & ~(W-1); next = base + ((addr + (1<<SIZE)) mod W).
- Burst error (SLVERR for the whole burst, no memory writes) when any of:
  - SIZE > log2(NB);
  - WRAP with LEN not in {1,3,7,15}, or start address not aligned to 1<<SIZE;
  - INCR with (start & 0xFFF) + ((LEN+1)<<SIZE) > 0x1000;
  - reserved burst type 11.
- Beat error: word index >= MEMORY_DEPTH gives DECERR for that beat; the beat is not written.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY at edge N, capture ID/addr/len/size/burst; at N+1 AWREADY=0, WREADY=1, state W_DATA.
  - W_DATA: each WVALID&WREADY writes the bytes whose WSTRB bit is 1 at that edge. A strobe-write beat with WSTRB=0 changes nothing.
  - Burst ends on the beat where beat count == LEN; WLAST is checked, not used for termination. WLAST mismatch on any beat gives SLVERR.
  - Cycle after the last beat: WREADY=0, BVALID=1, BID = captured AWID, state W_RESP.
  - BRESP priority: SLVERR > DECERR > OKAY, accumulated over the burst.
  - W_RESP: hold BVALID/BID/BRESP until BREADY; then W_IDLE with AWREADY=1 the next cycle.
- Read FSM (R_IDLE, R_FETCH, R_DATA):
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY at edge N, capture fields; go to R_FETCH with ARREADY=0.
  - R_FETCH: synchronous array read at N+1; RVALID=1 at N+2 in R_DATA.
  - R_DATA: RDATA/RRESP/RLAST/RID hold stable while RVALID & !RREADY.
  - RLAST=1 only on beat LEN. Error beats return RDATA=0 with RRESP=SLVERR or DECERR per beat.
  - On a non-last handshake: RVALID=0, advance address, R_FETCH (one bubble cycle per beat).
  - On the last handshake: RVALID=0, RLAST=0, R_IDLE.
- Channel concurrency: channels are fully concurrent. A read and a write to the same word in the same cycle: the read returns the pre-write data.
- LEN=0: single beat; RLAST=1 on it; write response after one W beat.

Test Plan:
1. INCR write AWID=5, AWADDR=0x0010, LEN=3, SIZE=2, WSTRB=F, data 0x11111111..0x44444444 → BRESP=00, BID=5. INCR read ARID=9 of the same range → 4 beats in order, RID=9, RLAST only on beat 4.
2. After 1, WRAP read ARADDR=0x0018, LEN=3, SIZE=2 → word addresses 0x18, 0x1C, 0x10, 0x14 → data 0x33333333, 0x44444444, 0x11111111, 0x22222222, all RRESP=00.
3. Word 0x40 = 0x12345678; write 0xAABBCCDD with WSTRB=0101 → readback 0x12BB56DD.
4. INCR AWADDR=0x0FF8, LEN=3, SIZE=2 → BRESP=10, words 0xFF8/0xFFC unchanged. Read ARADDR=0x1000, LEN=0 → RDATA=0, RRESP=11. WRAP with LEN=2 → SLVERR.
5. FIXED write 0x0020, LEN=2, data A, B, C → word 0x20 = C. Read with RREADY low 5 cycles → RVALID/RDATA held constant throughout.
6. Assert ARESETn low after beat 2 of an 8-beat write and read → all outputs at reset values asynchronously. After release, a new LEN=0 write/read completes with OKAY.
